// File: rtl/generador_ficha_param.sv
// ----------------------------------------------------------------------------
// generador_ficha_param
//
// Tile-spawn stage for an N x N 2048 board. After each move the caller
// presents the resulting board and pulses start. The block scans for an empty
// cell, beginning at a pseudo-random index and wrapping around, and writes a
// new tile (2 or 4) into the first empty cell it finds. The random source is
// an internal free-running Galois LFSR that can be reseeded at any time.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   start        spawn request, sampled only while idle
//   modo         0 = spawn a tile, 1 = pass the board through unchanged
//   semilla_wr   load semilla into the LFSR this cycle
//   semilla      new seed (zero is replaced by SEED)
//   tablero_in   board after the move, [row][col] of CELL_W-bit cells
//   tablero_out  resulting board, held until the next accepted start
//   ocupado      high while scanning (cycle after start up to listo)
//   listo        one-cycle done pulse
//   lleno        valid with listo: board had no empty cell
//   pos_fila     row of the placed tile, valid with listo when lleno=0
//   pos_col      column of the placed tile, valid with listo when lleno=0
// ----------------------------------------------------------------------------
module generador_ficha_param #(
    parameter int                N      = 4,
    parameter int                CELL_W = 32,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                P4_NUM = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 modo,
    input  logic                                 semilla_wr,
    input  logic [LFSR_W-1:0]                    semilla,
    input  logic [N-1:0][N-1:0][CELL_W-1:0]      tablero_in,
    output logic [N-1:0][N-1:0][CELL_W-1:0]      tablero_out,
    output logic                                 ocupado,
    output logic                                 listo,
    output logic                                 lleno,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] pos_fila,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] pos_col
);

    localparam int NN     = N * N;
    localparam int IDX_W  = (NN > 1) ? $clog2(NN) : 1;
    localparam int POS_W  = (N > 1) ? $clog2(N) : 1;
    localparam int K_W    = $clog2(NN + 1);
    localparam int PROD_W = LFSR_W + IDX_W;

    // Flat view of the board: cell [row][col] sits at linear index row*N+col,
    // which is exactly how the packed [N][N] port lays out its bits.
    typedef logic [NN-1:0][CELL_W-1:0] board_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [LFSR_W-1:0]      lfsr_reg;
    logic [LFSR_W-1:0]      lfsr_next;
    board_t                 work_reg;
    board_t                 out_reg;
    board_t                 in_board;
    board_t                 placed_board;
    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       idx_next;
    logic [IDX_W-1:0]       start_idx;
    logic [PROD_W-1:0]      start_prod;
    logic [K_W-1:0]         k_reg;
    logic [CELL_W-1:0]      tile_reg;
    logic [CELL_W-1:0]      tile_next;
    logic                   probe_empty;
    logic                   listo_reg;
    logic                   ocupado_reg;
    logic                   lleno_reg;
    logic [POS_W-1:0]       fila_reg;
    logic [POS_W-1:0]       col_reg;

    assign in_board = tablero_in;

    // LFSR runs in every state; a seed write wins over the shift, and a zero
    // seed would lock the register so it is replaced by SEED.
    always_comb begin
        lfsr_next = lfsr_reg >> 1;
        if (semilla_wr) begin
            lfsr_next = (semilla == '0) ? SEED : semilla;
        end else if (lfsr_reg[0]) begin
            lfsr_next = (lfsr_reg >> 1) ^ TAPS;
        end
    end

    // Start index scales the snapshot uniformly onto 0..NN-1.
    assign start_prod = PROD_W'(lfsr_reg) * PROD_W'(NN);
    assign start_idx  = IDX_W'(start_prod >> LFSR_W);

    // Tile value is decided from the same snapshot taken at accept time.
    assign tile_next = ({1'b0, lfsr_reg[3:0]} < 5'(P4_NUM)) ? CELL_W'(4) : CELL_W'(2);

    assign probe_empty = (work_reg[idx_reg] == '0);
    assign idx_next    = (idx_reg == IDX_W'(NN - 1)) ? '0 : idx_reg + 1'b1;

    // Work board with the tile dropped into the currently probed cell.
    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_place
            assign placed_board[gi] = (idx_reg == IDX_W'(gi)) ? tile_reg : work_reg[gi];
        end
    endgenerate

    // Outputs for the done cycle are loaded on the edge that enters DONE, so
    // listo, lleno, position and tablero_out all become valid together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            lfsr_reg    <= SEED;
            work_reg    <= '0;
            out_reg     <= '0;
            idx_reg     <= '0;
            k_reg       <= '0;
            tile_reg    <= '0;
            listo_reg   <= 1'b0;
            ocupado_reg <= 1'b0;
            lleno_reg   <= 1'b0;
            fila_reg    <= '0;
            col_reg     <= '0;
        end else begin
            lfsr_reg  <= lfsr_next;
            listo_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        work_reg <= in_board;
                        tile_reg <= tile_next;
                        idx_reg  <= start_idx;
                        k_reg    <= '0;
                        if (modo) begin
                            out_reg   <= in_board;
                            lleno_reg <= 1'b0;
                            listo_reg <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            ocupado_reg <= 1'b1;
                            state_reg   <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (probe_empty) begin
                        out_reg     <= placed_board;
                        fila_reg    <= POS_W'(idx_reg / IDX_W'(N));
                        col_reg     <= POS_W'(idx_reg % IDX_W'(N));
                        lleno_reg   <= 1'b0;
                        listo_reg   <= 1'b1;
                        ocupado_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else if (k_reg == K_W'(NN - 1)) begin
                        // Every cell probed and occupied: hand back the board as is.
                        out_reg     <= work_reg;
                        lleno_reg   <= 1'b1;
                        listo_reg   <= 1'b1;
                        ocupado_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else begin
                        idx_reg <= idx_next;
                        k_reg   <= k_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tablero_out = out_reg;
    assign ocupado     = ocupado_reg;
    assign listo       = listo_reg;
    assign lleno       = lleno_reg;
    assign pos_fila    = fila_reg;
    assign pos_col     = col_reg;

endmodule

// File: tb/tb_generador_ficha_param.sv
// ----------------------------------------------------------------------------
// tb_generador_ficha_param
//
// Directed and randomized spawns on a 4x4 board with a reference model that
// tracks the LFSR sequence and predicts the placement by scanning the board
// with plain arithmetic. Two extra instances with P4_NUM=0 and P4_NUM=16 run
// on the same stimulus to pin down the tile-value rule at its extremes.
// ----------------------------------------------------------------------------
module tb_generador_ficha_param;

    typedef logic [3:0][3:0][31:0] board_t;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        modo = 1'b0;
    logic        semilla_wr = 1'b0;
    logic [15:0] semilla = '0;
    board_t      tablero_in = '0;

    board_t      tablero_out, out_p0, out_p16;
    logic        ocupado, listo, lleno;
    logic        ocupado_p0, listo_p0, lleno_p0;
    logic        ocupado_p16, listo_p16, lleno_p16;
    logic [1:0]  pos_fila, pos_col, fila_p0, col_p0, fila_p16, col_p16;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    generador_ficha_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .modo(modo),
        .semilla_wr(semilla_wr), .semilla(semilla), .tablero_in(tablero_in),
        .tablero_out(tablero_out), .ocupado(ocupado), .listo(listo),
        .lleno(lleno), .pos_fila(pos_fila), .pos_col(pos_col)
    );

    generador_ficha_param #(.P4_NUM(0)) dut_p0 (
        .clk(clk), .rst_n(rst_n), .start(start), .modo(modo),
        .semilla_wr(semilla_wr), .semilla(semilla), .tablero_in(tablero_in),
        .tablero_out(out_p0), .ocupado(ocupado_p0), .listo(listo_p0),
        .lleno(lleno_p0), .pos_fila(fila_p0), .pos_col(col_p0)
    );

    generador_ficha_param #(.P4_NUM(16)) dut_p16 (
        .clk(clk), .rst_n(rst_n), .start(start), .modo(modo),
        .semilla_wr(semilla_wr), .semilla(semilla), .tablero_in(tablero_in),
        .tablero_out(out_p16), .ocupado(ocupado_p16), .listo(listo_p16),
        .lleno(lleno_p16), .pos_fila(fila_p16), .pos_col(col_p16)
    );

    // Reference LFSR: the documented Galois right-shift sequence.
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          m_lfsr <= SEED;
        else if (semilla_wr) m_lfsr <= (semilla == 16'h0) ? SEED : semilla;
        else                 m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_board(input string tag, input board_t obs, input board_t exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One spawn: called at a negedge with the DUT idle; returns one negedge
    // after the listo cycle so the DUT is idle again.
    task automatic spawn(input string name, input board_t b, input bit md,
                         output int place_out);
        logic [15:0] r;
        int          s, place, skipped, lat, cyc, row, col;
        logic [31:0] tile;
        board_t      exp_b;
        logic        ocup1, ocup1_p0, ocup1_p16;

        tablero_in = b;
        modo       = md;
        start      = 1'b1;
        r          = m_lfsr;

        s       = (int'(r) * 16) / 65536;
        place   = -1;
        skipped = 16;
        for (int j = 0; j < 16; j++) begin
            int c;
            c = (s + j) % 16;
            if (place < 0 && b[c / 4][c % 4] == 32'd0) begin
                place   = c;
                skipped = j;
            end
        end
        tile  = (int'(r % 16) < 1) ? 32'd4 : 32'd2;
        exp_b = b;
        row   = (place < 0) ? 0 : place / 4;
        col   = (place < 0) ? 0 : place % 4;
        if (place >= 0) exp_b[row][col] = tile;
        if (md) lat = 1;
        else    lat = (place >= 0) ? skipped + 2 : 17;

        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        ocup1     = ocupado;
        ocup1_p0  = ocupado_p0;
        ocup1_p16 = ocupado_p16;
        while (!listo && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end

        chk({name, ".latency"}, 64'(cyc), 64'(lat));
        chk({name, ".ocupado_at_listo"}, 64'(ocupado), 64'd0);
        if (md) begin
            chk_board({name, ".passthrough"}, tablero_out, b);
            chk({name, ".ocupado_c1"}, 64'(ocup1), 64'd0);
        end else begin
            chk({name, ".ocupado_c1"}, 64'(ocup1), 64'd1);
            chk({name, ".lleno"}, 64'(lleno), 64'(place < 0));
            chk_board({name, ".board"}, tablero_out, exp_b);
            chk({name, ".p0_listo"}, 64'(listo_p0), 64'd1);
            chk({name, ".p16_ocupado_c1"}, 64'(ocup1_p16 & ocup1_p0), 64'd1);
            if (place >= 0) begin
                chk({name, ".pos_fila"}, 64'(pos_fila), 64'(row));
                chk({name, ".pos_col"}, 64'(pos_col), 64'(col));
                chk({name, ".p0_tile"}, 64'(out_p0[row][col]), 64'd2);
                chk({name, ".p16_tile"}, 64'(out_p16[row][col]), 64'd4);
                chk({name, ".p16_pos"}, 64'({fila_p16, col_p16, fila_p0, col_p0}),
                    64'({row[1:0], col[1:0], row[1:0], col[1:0]}));
            end else begin
                chk({name, ".p16_lleno"}, 64'(lleno_p16 & lleno_p0), 64'd1);
            end
        end
        place_out = place;
        @(negedge clk);
    endtask

    function automatic board_t rand_board(input int density);
        board_t b;
        for (int c = 0; c < 16; c++) begin
            if (int'($urandom_range(0, 15)) < density) b[c / 4][c % 4] = 32'd0;
            else b[c / 4][c % 4] = 32'd1 << $urandom_range(1, 11);
        end
        return b;
    endfunction

    initial begin
        board_t b, full8, one_hole;
        int     pl, pl_a, pl_b;

        // Reset state
        tablero_in = rand_board(8);
        repeat (3) @(negedge clk);
        chk("reset.listo", 64'(listo), 64'd0);
        chk("reset.ocupado", 64'(ocupado), 64'd0);
        chk("reset.lleno_pos", 64'({lleno, pos_fila, pos_col}), 64'd0);
        chk_board("reset.board", tablero_out, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty board
        spawn("empty", '0, 1'b0, pl);
        $display("[TB] empty board -> placed at %0d", pl);

        // Full board of eights
        for (int c = 0; c < 16; c++) full8[c / 4][c % 4] = 32'd8;
        spawn("full", full8, 1'b0, pl);
        $display("[TB] full board -> place %0d", pl);

        // Only (2,3) empty, random seeds and random idle gaps
        for (int t = 0; t < 50; t++) begin
            one_hole = rand_board(0);
            one_hole[2][3] = 32'd0;
            semilla_wr = 1'b1;
            semilla    = 16'($urandom);
            @(negedge clk);
            semilla_wr = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            spawn("hole", one_hole, 1'b0, pl);
            chk("hole.index", 64'(pl), 64'd11);
            $display("[TB] hole seed=%h -> place %0d", semilla, pl);
        end

        // Pass-through mode
        for (int t = 0; t < 3; t++) begin
            b = rand_board(6);
            spawn("modo1", b, 1'b1, pl);
            $display("[TB] modo=1 pass-through transaction %0d", t);
        end

        // Random boards, random start timing
        for (int t = 0; t < 40; t++) begin
            b = rand_board(int'($urandom_range(0, 16)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            spawn("rand", b, 1'b0, pl);
            $display("[TB] random board %0d -> place %0d", t, pl);
        end

        // Reset in the middle of a full-board scan
        tablero_in = full8;
        modo  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstscan.ocupado_before", 64'(ocupado), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstscan.ocupado", 64'(ocupado), 64'd0);
        chk("rstscan.listo", 64'(listo), 64'd0);
        chk_board("rstscan.board", tablero_out, '0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rstscan.no_listo", 64'(listo | listo_p0 | listo_p16), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        spawn("after_rst", rand_board(5), 1'b0, pl);
        $display("[TB] reset mid-scan, next spawn -> place %0d", pl);

        // Zero seed twice with identical timing
        b = rand_board(7);
        b[0][0] = 32'd0;
        semilla_wr = 1'b1;
        semilla    = 16'h0;
        @(negedge clk);
        semilla_wr = 1'b0;
        repeat (3) @(negedge clk);
        spawn("seed0_a", b, 1'b0, pl_a);
        repeat (7) @(negedge clk);
        semilla_wr = 1'b1;
        semilla    = 16'h0;
        @(negedge clk);
        semilla_wr = 1'b0;
        repeat (3) @(negedge clk);
        spawn("seed0_b", b, 1'b0, pl_b);
        chk("seed0.repeat", 64'(pl_b), 64'(pl_a));
        $display("[TB] zero seed runs -> place %0d and %0d", pl_a, pl_b);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
